// File: rtl/break_reset_pkg.sv
// Shared types and sizing helpers for the UART-break reset requester.
package break_reset_pkg;

    typedef enum logic [2:0] {
        StIdle  = 3'd0,
        StArmed = 3'd1,
        StCount = 3'd2,
        StFire  = 3'd3,
        StRearm = 3'd4
    } state_e;

    // Bits needed to hold max_val, i.e. ceil(log2(max_val + 1)), never below 1.
    function automatic int unsigned cnt_width(input int unsigned max_val);
        int unsigned w;
        w = 1;
        for (int i = 1; i < 32; i++) begin
            if ((max_val >> i) != 0) begin
                w = i + 1;
            end
        end
        return w;
    endfunction

    function automatic int unsigned max_u(input int unsigned a, input int unsigned b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchronizer for the raw rx line; both flops reset to the idle-high level.
(* keep_hierarchy = "yes" *)
module sync_2ff (
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic i_d,
    output logic o_q
);

    logic r_meta;
    logic r_sync;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_meta <= 1'b1;
            r_sync <= 1'b1;
        end else begin
            r_meta <= i_d;
            r_sync <= r_meta;
        end
    end

    assign o_q = r_sync;

endmodule

// File: rtl/break_reset_req.sv
// Detects a sustained UART break on rx and issues one fixed-width reset_req pulse per break.
module break_reset_req
    import break_reset_pkg::*;
#(
    parameter int unsigned CLKS_PER_BIT = 16,
    parameter int unsigned BREAK_BITS   = 20,
    parameter int unsigned PULSE_CYCLES = 4
) (
    input  logic clk,
    input  logic rst_n,
    input  logic rx,
    input  logic enable,
    output logic reset_req,
    output logic armed
);

    localparam int unsigned RunLen = CLKS_PER_BIT * BREAK_BITS;
    localparam int unsigned CntW   = cnt_width(max_u(RunLen, PULSE_CYCLES));

    typedef logic [CntW-1:0] cnt_t;

    localparam cnt_t CntOne    = cnt_t'(1);
    localparam cnt_t BitLast   = cnt_t'(CLKS_PER_BIT - 1);
    localparam cnt_t RunLast   = cnt_t'(RunLen - 1);
    localparam cnt_t PulseLast = cnt_t'(PULSE_CYCLES - 1);

    logic   w_rx_s;
    state_e r_state;
    state_e w_state_nxt;
    cnt_t   r_cnt;
    cnt_t   w_cnt_nxt;
    logic   r_abort;
    logic   w_abort_nxt;
    logic   r_reset_req;
    logic   r_armed;

    sync_2ff u_sync_rx (
        .i_clk   (clk),
        .i_rst_n (rst_n),
        .i_d     (rx),
        .o_q     (w_rx_s)
    );

    // One counter serves as high-run prescaler (IDLE/REARM), low-run length (COUNT)
    // and pulse timer (FIRE).
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_abort_nxt = 1'b0;

        unique case (r_state)
            StIdle: begin
                if (!enable || !w_rx_s) begin
                    w_cnt_nxt = '0;
                end else if (r_cnt == BitLast) begin
                    w_state_nxt = StArmed;
                    w_cnt_nxt   = '0;
                end else begin
                    w_cnt_nxt = r_cnt + CntOne;
                end
            end

            StArmed: begin
                if (!enable) begin
                    w_state_nxt = StIdle;
                    w_cnt_nxt   = '0;
                end else if (!w_rx_s) begin
                    w_state_nxt = StCount;
                    w_cnt_nxt   = CntOne;
                end else begin
                    w_cnt_nxt = '0;
                end
            end

            StCount: begin
                // Losing enable takes priority over completing the run.
                if (!enable) begin
                    w_state_nxt = StIdle;
                    w_cnt_nxt   = '0;
                end else if (w_rx_s) begin
                    w_state_nxt = StArmed;
                    w_cnt_nxt   = '0;
                end else if (r_cnt >= RunLast) begin
                    w_state_nxt = StFire;
                    w_cnt_nxt   = '0;
                end else begin
                    w_cnt_nxt = r_cnt + CntOne;
                end
            end

            StFire: begin
                // The pulse always runs to completion; a dropped enable only picks the exit.
                w_abort_nxt = r_abort | ~enable;
                if (r_cnt == PulseLast) begin
                    w_state_nxt = w_abort_nxt ? StIdle : StRearm;
                    w_cnt_nxt   = '0;
                    w_abort_nxt = 1'b0;
                end else begin
                    w_cnt_nxt = r_cnt + CntOne;
                end
            end

            StRearm: begin
                if (!enable) begin
                    w_state_nxt = StIdle;
                    w_cnt_nxt   = '0;
                end else if (!w_rx_s) begin
                    w_cnt_nxt = '0;
                end else if (r_cnt == BitLast) begin
                    w_state_nxt = StArmed;
                    w_cnt_nxt   = '0;
                end else begin
                    w_cnt_nxt = r_cnt + CntOne;
                end
            end

            default: begin
                w_state_nxt = StIdle;
                w_cnt_nxt   = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= StIdle;
            r_cnt       <= '0;
            r_abort     <= 1'b0;
            r_reset_req <= 1'b0;
            r_armed     <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_cnt       <= w_cnt_nxt;
            r_abort     <= w_abort_nxt;
            r_reset_req <= (r_state == StFire);
            r_armed     <= (w_state_nxt == StArmed) || (w_state_nxt == StCount);
        end
    end

    assign reset_req = r_reset_req;
    assign armed     = r_armed;

endmodule

// File: tb/tb_break_reset_req.sv
// Segment-table bench for break_reset_req: per-cycle reset_req scoreboard plus armed spot checks.
module tb_break_reset_req;

    localparam int unsigned Cpb = 4;
    localparam int unsigned Bb  = 3;
    localparam int unsigned Pc  = 4;
    localparam int unsigned N   = Cpb * Bb;

    typedef struct {
        bit rst;
        bit rx;
        bit en;
        int len;
        bit fire;
        bit chk;
        bit arm;
    } seg_t;

    typedef struct {
        int unsigned edge_no;
        bit          exp_req;
        bit          chk;
        bit          arm;
    } exp_t;

    logic clk    = 1'b0;
    logic rst_n  = 1'b1;
    logic rx     = 1'b1;
    logic enable = 1'b0;
    logic reset_req;
    logic armed;

    int unsigned checks   = 0;
    int unsigned failures = 0;
    int unsigned edge_no  = 0;
    int unsigned win_q[$];
    exp_t        sb_q[$];
    seg_t        tbl[$];

    break_reset_req #(
        .CLKS_PER_BIT (Cpb),
        .BREAK_BITS   (Bb),
        .PULSE_CYCLES (Pc)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .rx        (rx),
        .enable    (enable),
        .reset_req (reset_req),
        .armed     (armed)
    );

    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL timeout edge=%0d actual=running required=finished", edge_no);
        $fatal(1, "bench timeout");
    end

    function automatic seg_t mk(input bit rst, input bit rx_v, input bit en_v, input int len,
                                input bit fire, input bit chk, input bit arm);
        seg_t s;
        s.rst  = rst;
        s.rx   = rx_v;
        s.en   = en_v;
        s.len  = len;
        s.fire = fire;
        s.chk  = chk;
        s.arm  = arm;
        return s;
    endfunction

    // Expected pulse: high after edges fall+N+2 .. fall+N+Pc+1.
    function automatic bit in_pulse(input int unsigned e);
        foreach (win_q[i]) begin
            if (e >= win_q[i] && e < win_q[i] + Pc) return 1'b1;
        end
        return 1'b0;
    endfunction

    task automatic check(input string name, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s edge=%0d actual=%b required=%b", name, edge_no, act, exp);
        end
    endtask

    // Called either at time 0 or 1 time unit after a rising edge; never overlaps an edge.
    task automatic do_reset();
        rst_n = 1'b0;
        win_q.delete();
        #2;
        check("rst_reset_req", reset_req, 1'b0);
        check("rst_armed", armed, 1'b0);
        #1;
        rst_n = 1'b1;
    endtask

    task automatic apply_seg(input seg_t s);
        exp_t x;
        if (s.rst) do_reset();
        if (s.fire) win_q.push_back(edge_no + 1 + N + 2);
        for (int c = 0; c < s.len; c++) begin
            rx     = s.rx;
            enable = s.en;
            x.edge_no = edge_no + 1;
            x.exp_req = in_pulse(edge_no + 1);
            x.chk     = s.chk && (c == s.len - 1);
            x.arm     = s.arm;
            sb_q.push_back(x);
            @(posedge clk);
            edge_no++;
            #1;
            x = sb_q.pop_front();
            if (x.edge_no != edge_no) begin
                failures++;
                $display("FAIL sb_order actual=%0d required=%0d", edge_no, x.edge_no);
            end
            check("reset_req", reset_req, x.exp_req);
            if (x.chk) check("armed", armed, x.arm);
        end
    endtask

    initial begin
        rst_n = 1'b0;

        //               rst  rx    en    len fire  chk   arm
        // Scenarios 1, 3 and 2 back to back.
        tbl.push_back(mk(1'b1, 1'b1, 1'b1,  8, 1'b0, 1'b1, 1'b1));
        tbl.push_back(mk(1'b0, 1'b0, 1'b1, 30, 1'b1, 1'b1, 1'b0));
        tbl.push_back(mk(1'b0, 1'b1, 1'b1,  3, 1'b0, 1'b1, 1'b0));
        tbl.push_back(mk(1'b0, 1'b0, 1'b1, 12, 1'b0, 1'b1, 1'b0));
        tbl.push_back(mk(1'b0, 1'b1, 1'b1,  4, 1'b0, 1'b1, 1'b0));
        tbl.push_back(mk(1'b0, 1'b0, 1'b1, 12, 1'b1, 1'b1, 1'b1));
        tbl.push_back(mk(1'b0, 1'b1, 1'b1, 12, 1'b0, 1'b1, 1'b1));
        tbl.push_back(mk(1'b0, 1'b0, 1'b1, 11, 1'b0, 1'b1, 1'b1));
        tbl.push_back(mk(1'b0, 1'b1, 1'b1,  1, 1'b0, 1'b1, 1'b1));
        tbl.push_back(mk(1'b0, 1'b0, 1'b1, 12, 1'b1, 1'b1, 1'b1));
        tbl.push_back(mk(1'b0, 1'b1, 1'b1, 12, 1'b0, 1'b1, 1'b1));
        // Scenario 4: enable low from the second FIRE cycle; pulse keeps full width.
        tbl.push_back(mk(1'b1, 1'b1, 1'b1,  8, 1'b0, 1'b1, 1'b1));
        tbl.push_back(mk(1'b0, 1'b0, 1'b1, 15, 1'b1, 1'b1, 1'b0));
        tbl.push_back(mk(1'b0, 1'b0, 1'b0, 10, 1'b0, 1'b1, 1'b0));
        tbl.push_back(mk(1'b0, 1'b0, 1'b1, 12, 1'b0, 1'b1, 1'b0));
        tbl.push_back(mk(1'b0, 1'b1, 1'b1,  8, 1'b0, 1'b1, 1'b1));
        // Scenario 6: enable low exactly on the 12th low sample.
        tbl.push_back(mk(1'b0, 1'b0, 1'b1, 13, 1'b0, 1'b1, 1'b1));
        tbl.push_back(mk(1'b0, 1'b0, 1'b0,  1, 1'b0, 1'b1, 1'b0));
        tbl.push_back(mk(1'b0, 1'b0, 1'b1, 10, 1'b0, 1'b1, 1'b0));

        foreach (tbl[i]) apply_seg(tbl[i]);

        // Scenario 5: reset mid-COUNT, then mid-FIRE, then a fresh high+low is needed.
        apply_seg(mk(1'b1, 1'b1, 1'b1,  8, 1'b0, 1'b1, 1'b1));
        apply_seg(mk(1'b0, 1'b0, 1'b1,  6, 1'b0, 1'b1, 1'b1));
        do_reset();
        apply_seg(mk(1'b0, 1'b1, 1'b1,  8, 1'b0, 1'b1, 1'b1));
        apply_seg(mk(1'b0, 1'b0, 1'b1, 16, 1'b1, 1'b1, 1'b0));
        check("pulse_before_rst", reset_req, 1'b1);
        do_reset();
        apply_seg(mk(1'b0, 1'b0, 1'b1, 20, 1'b0, 1'b1, 1'b0));
        apply_seg(mk(1'b0, 1'b1, 1'b1,  4, 1'b0, 1'b1, 1'b0));
        apply_seg(mk(1'b0, 1'b0, 1'b1, 12, 1'b1, 1'b1, 1'b1));
        apply_seg(mk(1'b0, 1'b1, 1'b1, 12, 1'b0, 1'b1, 1'b1));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
